// File: rtl/riscv_pkg.sv
// Shared RV32I control definitions: opcodes, instruction classes and
// the encodings used by the multi-cycle controller's datapath selects.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Bit positions in the one-hot instruction class vector.
  localparam int unsigned CLS_R      = 0;
  localparam int unsigned CLS_I      = 1;
  localparam int unsigned CLS_LOAD   = 2;
  localparam int unsigned CLS_STORE  = 3;
  localparam int unsigned CLS_BRANCH = 4;
  localparam int unsigned CLS_JAL    = 5;
  localparam int unsigned NUM_CLS    = 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier: 7-bit opcode to one-hot instruction
// class plus an illegal bit for anything outside the supported subset.
module opcode_class_decode
  import riscv_pkg::*;
(
  input  logic [6:0]         opcode_i,
  output logic [NUM_CLS-1:0] class_o,
  output logic               illegal_o
);

  // Map each supported opcode to its class bit; everything else is illegal.
  always_comb begin
    class_o   = '0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_R:      class_o[CLS_R]      = 1'b1;
      OP_I:      class_o[CLS_I]      = 1'b1;
      OP_LOAD:   class_o[CLS_LOAD]   = 1'b1;
      OP_STORE:  class_o[CLS_STORE]  = 1'b1;
      OP_BRANCH: class_o[CLS_BRANCH] = 1'b1;
      OP_JAL:    class_o[CLS_JAL]    = 1'b1;
      default:   illegal_o           = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: owns the instruction register and
// sequences fetch, decode, execute, memory and write-back.
// Optional performance counters are enabled with `define PERF_CNT_EN.
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  input  logic                  imem_ready,
  input  logic [ADDR_WIDTH-1:0] imem_rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  input  logic                  dmem_ready,
  input  logic                  branch_taken,
  output logic [ADDR_WIDTH-1:0] ir,
  output logic                  pc_we,
  output logic [1:0]            pc_sel,
  output logic                  alu_src,
  output logic [1:0]            alu_op,
  output logic                  reg_we,
  output logic [1:0]            wb_sel,
  output logic                  illegal,
  output logic [2:0]            state
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]           cycle_cnt,
  output logic [31:0]           instret_cnt
`endif
);

  localparam logic [ADDR_WIDTH-1:0] IR_NOP = ADDR_WIDTH'(32'h0000_0013);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ir_q, ir_d;
  logic [NUM_CLS-1:0]      cls;
  logic                    op_illegal;

  opcode_class_decode u_decode (
    .opcode_i  (ir_q[6:0]),
    .class_o   (cls),
    .illegal_o (op_illegal)
  );

  // State and instruction register; reset aborts any pending request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= IR_NOP;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state and datapath controls, all derived from state and IR.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_PLUS4;
    alu_src  = 1'b0;
    alu_op   = ALU_ADD;
    reg_we   = 1'b0;
    wb_sel   = WB_ALU;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = op_illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (cls[CLS_R]) begin
          alu_op  = ALU_FUNCT;
          state_d = S_WB;
        end else if (cls[CLS_I]) begin
          alu_src = 1'b1;
          alu_op  = ALU_FUNCT;
          state_d = S_WB;
        end else if (cls[CLS_LOAD] || cls[CLS_STORE]) begin
          alu_src = 1'b1;
          state_d = S_MEM;
        end else if (cls[CLS_BRANCH]) begin
          alu_op  = ALU_SUB;
          pc_we   = 1'b1;
          pc_sel  = branch_taken ? PC_BRANCH : PC_PLUS4;
          state_d = S_FETCH;
        end else if (cls[CLS_JAL]) begin
          state_d = S_WB;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cls[CLS_STORE];
        if (dmem_ready) begin
          if (cls[CLS_STORE]) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        state_d = S_FETCH;
        if (cls[CLS_JAL]) begin
          wb_sel = WB_PC4;
          pc_sel = PC_BRANCH;
        end else if (cls[CLS_LOAD]) begin
          wb_sel = WB_LOAD;
        end
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // TRAP is only left through reset, so the state itself is the sticky flag.
  assign illegal = (state_q == S_TRAP);
  assign ir      = ir_q;
  assign state   = state_q;

`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt_q, instret_cnt_q;

  // Active-cycle and retired-instruction counters; both wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_TRAP) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (pc_we) instret_cnt_q <= instret_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle control FSM for the RV32I core.
- Owns the instruction register (IR) and drives `ir` to the immediate generator, whose opcode input is `ir[6:0]`.
- Sequences fetch, decode, execute, memory and write-back, handshaking with instruction and data memory.
- Produces PC, ALU, register-file and write-back selects for the datapath.

Parameters:
- ADDR_WIDTH, 32, width of instruction word and of IR.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction fetch request, held until accepted.
- imem_ready  in  1  fetch accepted; `imem_rdata` valid this cycle.
- imem_rdata  in  ADDR_WIDTH  fetched instruction.
- dmem_req  out  1  data access request, held until accepted.
- dmem_we  out  1  1 = store, 0 = load; valid while `dmem_req`=1.
- dmem_ready  in  1  data access completes this cycle.
- branch_taken  in  1  branch condition from ALU compare, valid in EXEC.
- ir  out  ADDR_WIDTH  latched instruction.
- pc_we  out  1  PC update strobe; also the retire pulse.
- pc_sel  out  2  00 = pc+4, 01 = pc+ImmExt, others reserved.
- alu_src  out  1  0 = rs2, 1 = ImmExt.
- alu_op  out  2  00 = add, 01 = compare/sub, 10 = funct-decoded.
- reg_we  out  1  register-file write strobe.
- wb_sel  out  2  00 = ALU, 01 = load data, 10 = pc+4.
- illegal  out  1  sticky unsupported-opcode flag.
- state  out  3  current FSM state, for debug.

Behaviour:
- Interface: one clock, `clk`. `reset` is asynchronous and active-high.
- States:
  - IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, TRAP = 6.
  - State and IR are registered.
  - All other outputs are combinational from state and IR.
- Reset, asserted at any time:
  - state = IDLE, IR = 0x00000013 (NOP), `illegal` = 0.
  - All strobes and requests are 0 immediately, aborting any pending memory request.
- Transitions:
  - IDLE:
    - all strobes 0.
    - go to FETCH next cycle unconditionally.
  - FETCH:
    - `imem_req` = 1.
    - Stay while `imem_ready` = 0.
    - On `imem_ready`: IR <= `imem_rdata`, go to DECODE.
  - DECODE:
    - Supported opcodes: 0110011 (R), 0010011 (I), 0000011 (load), 0100011 (store), 1100011 (branch), 1101111 (JAL).
    - Any other opcode -> TRAP; otherwise -> EXEC.
  - EXEC:
    - R -> WB: `alu_src` = 0, `alu_op` = 10.
    - I -> WB: `alu_src` = 1, `alu_op` = 10.
    - Load/store -> MEM: `alu_src` = 1, `alu_op` = 00.
    - Branch -> FETCH: `alu_op` = 01, `pc_we` = 1, `pc_sel` = `branch_taken` ? 01 : 00.
    - JAL -> WB.
  - MEM:
    - `dmem_req` = 1, `dmem_we` = store. Stay while `dmem_ready` = 0.
    - On `dmem_ready`, load -> WB.
    - On `dmem_ready`, store -> FETCH with `pc_we` = 1, `pc_sel` = 00.
  - WB:
    - `reg_we` = 1, `pc_we` = 1. Then -> FETCH.
    - `wb_sel`: 00 for R/I, 01 for load, 10 for JAL.
    - `pc_sel`: 01 for JAL, else 00.
  - TRAP:
    - `illegal` = 1, all strobes 0.
    - Stays in TRAP until reset.
- Latency with zero-wait memories (FETCH lasts 1 cycle), cycles per instruction:
  - branch 3, store 4, R/I 4, JAL 4, load 5.
  - Each memory wait cycle adds 1.
- Strobe widths:
  - `reg_we` and `pc_we` are exactly 1 cycle per instruction.
  - `pc_we` asserts exactly once per retired instruction.
- IR changes only on the FETCH accept edge.
- `reg_we` asserts for rd = x0 as for any rd; the register file drops the write.
- `imem_req` and `dmem_req` are never asserted in the same cycle.

Optional Feature:
- Macro: PERF_CNT_EN.
- Defined:
  - Adds outputs `cycle_cnt` [31:0] and `instret_cnt` [31:0], both reset to 0.
  - `cycle_cnt` increments every cycle outside IDLE and TRAP.
  - `instret_cnt` increments on each `pc_we`.
  - Both wrap 0xFFFFFFFF -> 0.
- Undefined: the ports and counters are absent, with no other behavioural difference.

Decomposition:
- Shared package `riscv_pkg`, containing:
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL);
  - state enum, `pc_sel` enum, `wb_sel` enum, `alu_op` enum.
- One natural sub-module, `opcode_class_decode`:
  - combinational, 7-bit opcode -> one-hot instruction class plus an illegal bit.
  - Shared with the FSM's DECODE and EXEC logic.

Test Plan:
1. Reset mid-MEM with `dmem_req` high -> `dmem_req` drops same cycle, state = 0, IR = 0x00000013; after release: IDLE, then FETCH with `imem_req` = 1.
2. ADDI x1,x0,5 (0x00500093), zero-wait -> FETCH, DECODE, EXEC (`alu_src` = 1), WB (`reg_we` = 1, `wb_sel` = 00, `pc_we` = 1, `pc_sel` = 00); 4 cycles total.
3. LW with `dmem_ready` held low 3 cycles -> `dmem_req` = 1 and `dmem_we` = 0 for 4 cycles, then WB with `wb_sel` = 01; 8 cycles total.
4. BEQ with `branch_taken` = 1, then again with `branch_taken` = 0 -> `pc_we` pulse in EXEC with `pc_sel` = 01 and 00 respectively; no `reg_we`.
5. JAL (0x0080006F) -> WB with `wb_sel` = 10, `pc_sel` = 01, `reg_we` = 1.
6. LUI (0x000000B7) -> TRAP, `illegal` = 1 held for 10+ cycles, no strobes; cleared only by reset. With PERF_CNT_EN defined, `instret_cnt` equals the count of retired instructions before the trap.
